// File: rtl/pipe_ctrl_pkg.sv
// Shared helpers for the credit-controlled pipeline block: counter width helper
// and the statistics counter width.
package pipe_ctrl_pkg;

  localparam int STATS_W = 32;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_credit_ctrl_result_fifo.sv
// result_fifo: synchronous FIFO holding datapath results until the consumer
// takes them; clr empties it like rst but leaves storage contents alone.
module result_fifo
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic             full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en && !clr;
  assign do_rd   = rd_en && !clr && (count != '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates validity, so stale
  // entries are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // The credit rule upstream guarantees a result always has a free slot.
  a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(do_wr && full));

endmodule

// File: rtl/pipe_credit_ctrl.sv
// pipe_credit_ctrl: credit-based issue control for a fixed-latency, non-stallable
// datapath. Optional PIPE_CREDIT_CTRL_STATS_EN adds issue/stall counters.
module pipe_credit_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  pipe_en,
  output logic [WIDTH-1:0]      pipe_data,
  input  logic [WIDTH-1:0]      pipe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [cnt_w(N)-1:0]   inflight
`ifdef PIPE_CREDIT_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0]    issue_cnt,
  output logic [STATS_W-1:0]    stall_cnt
`endif
);

  localparam int IW = cnt_w(N);
  localparam int BW = cnt_w(DEPTH);

  logic [N-1:0]     vsr;
  logic [IW-1:0]    inflight_raw;
  logic [BW-1:0]    buf_count;
  logic [WIDTH-1:0] head;
  logic             has_credit;
  logic             issue;
  logic             pop;

  assign inflight_raw = IW'($countones(vsr));

  // Credit depends on registered state only, so a pop frees a slot a cycle later.
  assign has_credit = (32'(buf_count) + 32'(inflight_raw)) < 32'(DEPTH);
  assign in_ready   = !rst && !flush && has_credit;
  assign issue      = in_valid && in_ready;
  assign pipe_en    = issue;
  assign pipe_data  = in_data;

  assign out_valid  = !rst && (buf_count != '0);
  assign out_data   = out_valid ? head : '0;
  assign pop        = out_valid && out_ready && !flush;
  assign inflight   = rst ? '0 : inflight_raw;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vsr <= '0;
    end else begin
      vsr[0] <= issue;
      for (int i = 1; i < N; i++) vsr[i] <= vsr[i-1];
    end
  end

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (vsr[N-1] && !flush),
    .wr_data (pipe_result),
    .rd_en   (pop),
    .rd_data (head),
    .count   (buf_count)
  );

`ifdef PIPE_CREDIT_CTRL_STATS_EN
  // Saturating counters; flush deliberately leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && (issue_cnt != '1)) issue_cnt <= issue_cnt + STATS_W'(1);
      if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Directed bench for pipe_credit_ctrl with an identity N-stage datapath model;
// covers PIPE_CREDIT_CTRL_STATS_EN counters when that macro is defined.
module tb_pipe_credit_ctrl;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             pipe_en;
  logic [WIDTH-1:0] pipe_data;
  logic [WIDTH-1:0] pipe_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       inflight;
`ifdef PIPE_CREDIT_CTRL_STATS_EN
  logic [31:0]      issue_cnt;
  logic [31:0]      stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_credit_ctrl #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .pipe_en     (pipe_en),
    .pipe_data   (pipe_data),
    .pipe_result (pipe_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .inflight    (inflight)
`ifdef PIPE_CREDIT_CTRL_STATS_EN
    ,
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Non-stallable identity datapath: operand appears N cycles after issue.
  logic [WIDTH-1:0] dp [N];
  always @(posedge clk) begin
    dp[0] <= pipe_data;
    for (int i = 1; i < N; i++) dp[i] <= dp[i-1];
  end
  assign pipe_result = dp[N-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;

    // Reset values
    tick();
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_pipe_en",   32'(pipe_en),   32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inflight",  32'(inflight),  32'd0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_pipe_data", 32'(pipe_data), 32'h55);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back 0x11,0x22,0x33, first result at t+5
    tick();
    in_valid = 1'b1; in_data = 8'h11;
    #1;
    check("b2b_pipe_en",   32'(pipe_en),   32'd1);
    check("b2b_pipe_data", 32'(pipe_data), 32'h11);
    tick(); in_data = 8'h22;
    tick(); in_data = 8'h33;
    tick(); in_valid = 1'b0;
    #1;
    check("b2b_inflight3", 32'(inflight), 32'd3);
    tick(); check("b2b_t4_valid", 32'(out_valid), 32'd0);
    tick(); check("b2b_t5_valid", 32'(out_valid), 32'd1); check("b2b_t5_data", 32'(out_data), 32'h11);
    tick(); check("b2b_t6_valid", 32'(out_valid), 32'd1); check("b2b_t6_data", 32'(out_data), 32'h22);
    tick(); check("b2b_t7_valid", 32'(out_valid), 32'd1); check("b2b_t7_data", 32'(out_data), 32'h33);
    tick(); check("b2b_t8_valid", 32'(out_valid), 32'd0);

    // Blocked consumer: exactly DEPTH issues, occupancy conserved
    out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(c);
      #1;
      check("fill_occupancy", 32'(inflight) + 32'(dut.u_fifo.count), (c < 8) ? c : 8);
      check("fill_pipe_en", 32'(pipe_en), (c < 8) ? 32'd1 : 32'd0);
      tick();
    end

    // Single-cycle pop on a full buffer releases exactly one credit
    in_valid = 1'b1; in_data = 8'h48; out_ready = 1'b1;
    #1;
    check("pulse_in_ready0", 32'(in_ready),  32'd0);
    check("pulse_head",      32'(out_data),  32'h40);
    tick();
    out_ready = 1'b0;
    #1;
    check("pulse_in_ready1", 32'(in_ready),  32'd1);
    check("pulse_issue",     32'(pipe_en),   32'd1);
    check("pulse_data",      32'(pipe_data), 32'h48);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("pulse_no_more", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data",  32'(out_data),  32'h40 + 32'(k));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Flush with 2 buffered and 3 in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h61; tick();
    in_data = 8'h62; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h63; tick();
    in_data = 8'h64; tick();
    in_data = 8'h65; tick();
    in_data = 8'h99; flush = 1'b1;
    #1;
    check("flush_in_ready",  32'(in_ready),  32'd0);
    check("flush_pipe_en",   32'(pipe_en),   32'd0);
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    check("flush_pre_head",  32'(out_data),  32'h61);
    check("flush_pre_infl",  32'(inflight),  32'd3);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("flush_post_valid", 32'(out_valid), 32'd0);
    check("flush_post_infl",  32'(inflight),  32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("flush_discard", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("flush_next_wait", 32'(out_valid), 32'd0);
    tick();
    check("flush_next_valid", 32'(out_valid), 32'd1);
    check("flush_next_data",  32'(out_data),  32'h77);
    tick();
    check("flush_next_alone", 32'(out_valid), 32'd0);

    // Reset mid-stream with buffered and in-flight items
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'h81 + 8'(i);
      tick();
    end
    rst = 1'b1; in_data = 8'h87;
    #1;
    check("mrst_in_ready",  32'(in_ready),  32'd0);
    check("mrst_pipe_en",   32'(pipe_en),   32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_inflight",  32'(inflight),  32'd0);
    check("mrst_out_data",  32'(out_data),  32'h0);
    check("mrst_pipe_data", 32'(pipe_data), 32'h87);
    tick();
    rst = 1'b0; in_data = 8'h90; out_ready = 1'b1;
    #1;
    check("mrst_next_ready", 32'(in_ready),  32'd1);
    check("mrst_next_issue", 32'(pipe_en),   32'd1);
    check("mrst_next_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("mrst_no_stale", 32'(out_valid), 32'd0);
      tick();
    end
    check("mrst_ret_valid", 32'(out_valid), 32'd1);
    check("mrst_ret_data",  32'(out_data),  32'h90);
    tick();
    check("mrst_ret_alone", 32'(out_valid), 32'd0);

`ifdef PIPE_CREDIT_CTRL_STATS_EN
    // 10 issues, then 6 stalled cycles (flush holds in_ready low)
    rst = 1'b1; tick();
    rst = 1'b0;
    check("stats_clear_issue", issue_cnt, 32'd0);
    check("stats_clear_stall", stall_cnt, 32'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    flush = 1'b1;
    repeat (6) tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    check("stats_issue_cnt", issue_cnt, 32'd10);
    check("stats_stall_cnt", stall_cnt, 32'd6);
    repeat (10) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
